// File: rtl/ysyx_lsu_axi_bridge.sv
// ysyx_lsu_axi_bridge
//   Converts the LSU's level-held load/store requests into AXI4-Lite master
//   transactions, one at a time. Stores are lane-aligned here; loads return the
//   raw bus word and the LSU extracts bytes itself.
//
// Ports
//   clk, rst                          clock, async active-high reset
//   lsu_araddr/arvalid/rstrb          load request (held until lsu_rvalid)
//   lsu_rdata/lsu_rvalid              load result, one-cycle pulse
//   lsu_awaddr/awvalid/wdata/wstrb/wvalid
//                                     store request (LSB-aligned data/mask)
//   lsu_wready                        store complete, one-cycle pulse
//   ar*/r*/aw*/w*/b*                  AXI4-Lite master channels
//   bus_err                           sticky response-error flag
//
// Configuration
//   YSYX_LSU_BUS_ERR_EN  when defined, a non-OKAY rresp/bresp sets bus_err
//                        (sticky until rst) and an error read returns 0.
//                        When undefined, responses are ignored, bus_err = 0.
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | no transaction; accepts a request unless retiring
// RADDR  | arvalid high, waiting for arready
// RDATA  | rready high, waiting for rvalid
// WREQ   | aw/w channels completing independently
// WRESP  | bready high, waiting for bvalid

module ysyx_lsu_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic                  lsu_arvalid,
  input  logic [7:0]            lsu_rstrb,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_rvalid,
  input  logic [ADDR_W-1:0]     lsu_awaddr,
  input  logic                  lsu_awvalid,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [7:0]            lsu_wstrb,
  input  logic                  lsu_wvalid,
  output logic                  lsu_wready,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  output logic [2:0]            arsize,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  output logic [2:0]            awsize,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  bus_err
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WREQ,
    S_WRESP
  } state_t;

  state_t state, state_nxt;

  logic             aw_done, w_done;
  logic             ld_go, st_go;
  logic             r_hs, b_hs, aw_fin, w_fin;
  logic             rd_err, wr_err;
  logic [OFF_W-1:0] st_off;
  logic             unused_lsu;

  function automatic logic [2:0] size_of(input logic [7:0] mask);
    case (mask)
      8'h01:   size_of = 3'd0;
      8'h03:   size_of = 3'd1;
      default: size_of = 3'd2;
    endcase
  endfunction

  assign st_off     = lsu_awaddr[OFF_W-1:0];
  assign unused_lsu = ^lsu_wstrb[7:LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    ld_go     = 1'b0;
    st_go     = 1'b0;
    r_hs      = 1'b0;
    b_hs      = 1'b0;
    aw_fin    = 1'b0;
    w_fin     = 1'b0;
    case (state)
      S_IDLE: begin
        // A completion pulse cycle belongs to the LSU retiring the previous
        // access; its request lines are still up and must not be re-accepted.
        if (!(lsu_rvalid || lsu_wready)) begin
          if (lsu_arvalid) begin
            ld_go     = 1'b1;
            state_nxt = S_RADDR;
          end else if (lsu_awvalid && lsu_wvalid) begin
            st_go     = 1'b1;
            state_nxt = S_WREQ;
          end
        end
      end
      S_RADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_RDATA;
      end
      S_RDATA: begin
        rready = 1'b1;
        r_hs   = rvalid;
        if (rvalid) state_nxt = S_IDLE;
      end
      S_WREQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        aw_fin  = aw_done || awready;
        w_fin   = w_done || wready;
        if (aw_fin && w_fin) state_nxt = S_WRESP;
      end
      S_WRESP: begin
        bready = 1'b1;
        b_hs   = bvalid;
        if (bvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef YSYX_LSU_BUS_ERR_EN
  assign rd_err = |rresp;
  assign wr_err = |bresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   bus_err <= 1'b0;
    else if ((r_hs && rd_err) || (b_hs && wr_err)) bus_err <= 1'b1;
  end
`else
  logic unused_resp;
  assign rd_err      = 1'b0;
  assign wr_err      = 1'b0;
  assign bus_err     = 1'b0;
  assign unused_resp = ^{rresp, bresp, wr_err};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      araddr     <= '0;
      arsize     <= 3'd0;
      awaddr     <= '0;
      awsize     <= 3'd0;
      wdata      <= '0;
      wstrb      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      lsu_rdata  <= '0;
      lsu_rvalid <= 1'b0;
      lsu_wready <= 1'b0;
    end else begin
      lsu_rvalid <= r_hs;
      lsu_wready <= b_hs;
      if (ld_go) begin
        araddr <= lsu_araddr;
        arsize <= size_of(lsu_rstrb);
      end
      if (st_go) begin
        awaddr  <= lsu_awaddr;
        awsize  <= size_of(lsu_wstrb);
        // Lanes shifted past the top of the word are dropped, not split.
        wstrb   <= lsu_wstrb[LANES-1:0] << st_off;
        wdata   <= lsu_wdata << {st_off, 3'b000};
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
      if (r_hs) lsu_rdata <= rd_err ? '0 : rdata;
    end
  end

endmodule

// File: tb/tb_ysyx_lsu_axi_bridge.sv
module tb_ysyx_lsu_axi_bridge;

`ifdef YSYX_LSU_BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
  logic        lsu_arvalid, lsu_rvalid, lsu_awvalid, lsu_wvalid, lsu_wready;
  logic [7:0]  lsu_rstrb, lsu_wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wvalid, wready, bvalid, bready, bus_err;
  logic [2:0]  arsize, awsize;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  ysyx_lsu_axi_bridge dut (
    .clk(clk), .rst(rst),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .araddr(araddr), .arvalid(arvalid), .arsize(arsize), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awsize(awsize), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bus_err(bus_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- slave model: per-transaction wait counts ----------------
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic [31:0] r_data;
  logic [1:0]  r_resp, b_resp;

  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      end else begin
        arready = 0;
        if (arvalid) begin if (ar_cnt > 0) ar_cnt--; else arready = 1; end
        awready = 0;
        if (awvalid) begin if (aw_cnt > 0) aw_cnt--; else awready = 1; end
        wready = 0;
        if (wvalid) begin if (w_cnt > 0) w_cnt--; else wready = 1; end
        rvalid = 0; rdata = $urandom; rresp = 2'($urandom);
        if (rready) begin
          if (r_cnt > 0) r_cnt--;
          else begin rvalid = 1; rdata = r_data; rresp = r_resp; end
        end
        bvalid = 0; bresp = 2'($urandom);
        if (bready) begin
          if (b_cnt > 0) b_cnt--;
          else begin bvalid = 1; bresp = b_resp; end
        end
      end
    end
  end

  // ---------------- channel monitor ----------------
  logic [34:0] ar_q[$], aw_q[$];
  logic [35:0] w_q[$];
  int          r_hs, b_hs;
  bit          ar_pend, aw_pend, w_pend;
  logic [35:0] ar_prev, aw_prev;
  logic [36:0] w_prev;

  always @(negedge clk) begin
    if (rst) begin
      ar_pend = 0; aw_pend = 0; w_pend = 0;
    end else begin
      if (ar_pend) chk("ar_stable", {arvalid, arsize, araddr}, ar_prev);
      if (aw_pend) chk("aw_stable", {awvalid, awsize, awaddr}, aw_prev);
      if (w_pend)  chk("w_stable",  {wvalid, wstrb, wdata}, w_prev);
      if (arvalid && arready) ar_q.push_back({arsize, araddr});
      if (awvalid && awready) aw_q.push_back({awsize, awaddr});
      if (wvalid && wready)   w_q.push_back({wstrb, wdata});
      if (rvalid && rready) r_hs++;
      if (bvalid && bready) b_hs++;
      ar_pend = arvalid && !arready; ar_prev = {1'b1, arsize, araddr};
      aw_pend = awvalid && !awready; aw_prev = {1'b1, awsize, awaddr};
      w_pend  = wvalid && !wready;   w_prev  = {1'b1, wstrb, wdata};
    end
  end

  // ---------------- reference model ----------------
  bit exp_err;

  function automatic logic [2:0] exp_size(input logic [7:0] s);
    if (s == 8'h01) return 3'd0;
    if (s == 8'h03) return 3'd1;
    return 3'd2;
  endfunction

  function automatic logic [35:0] exp_wbeat(input logic [31:0] a, input logic [7:0] s,
                                            input logic [31:0] d);
    int          o;
    logic [3:0]  st;
    logic [31:0] dd;
    o  = int'(a[1:0]);
    st = 4'((s & 8'h0f) << o);
    dd = d << (8 * o);
    return {st, dd};
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic drop_req();
    lsu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0;
  endtask

  // Waits for the completion pulse; cycle 0 is the cycle the request is driven.
  task automatic wait_pulse(input bit is_ld, input bit mess, output int lat,
                            output logic [31:0] rd_seen);
    bit got, other;
    got = 0; other = 0; lat = -1; rd_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) chk("pulse_width", {lsu_rvalid, lsu_wready}, 2'b00);
      if (is_ld ? lsu_wready : lsu_rvalid) other = 1;
      if (is_ld ? lsu_rvalid : lsu_wready) begin
        got = 1; lat = i; rd_seen = lsu_rdata;
        break;
      end
      if (mess && i >= 1) begin
        lsu_araddr = $urandom; lsu_awaddr = $urandom; lsu_wdata = $urandom;
        lsu_rstrb = 8'($urandom); lsu_wstrb = 8'($urandom);
        if ($urandom_range(0, 1) == 1) drop_req();
      end
    end
    chk("pulse_seen", got, 1'b1);
    chk("wrong_pulse", other, 1'b0);
    @(posedge clk); #1;
    drop_req();
  endtask

  task automatic start_txn();
    ar_q.delete(); aw_q.delete(); w_q.delete();
    r_hs = 0; b_hs = 0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [7:0] strb,
                         input logic [31:0] data, input logic [1:0] resp,
                         input int arw, input int rw, input bit mess, input bit also_st);
    int lat;
    logic [31:0] rd;
    start_txn();
    ar_cnt = arw; r_cnt = rw; r_data = data; r_resp = resp;
    lsu_araddr = addr; lsu_rstrb = strb; lsu_arvalid = 1;
    if (also_st) begin
      lsu_awaddr = $urandom; lsu_wdata = $urandom; lsu_wstrb = 8'h0f;
      lsu_awvalid = 1; lsu_wvalid = 1;
    end
    wait_pulse(1'b1, mess, lat, rd);
    if (ERR_EN && resp != 2'b00) exp_err = 1;
    chk("ld_latency", lat, 3 + arw + rw);
    chk("ld_ar_count", ar_q.size(), 1);
    if (ar_q.size() > 0) chk("ld_ar_beat", ar_q[0], {exp_size(strb), addr});
    chk("ld_r_count", r_hs, 1);
    chk("ld_no_aw", aw_q.size() + w_q.size(), 0);
    chk("ld_rdata", rd, (ERR_EN && resp != 2'b00) ? 32'h0 : data);
    chk("bus_err", bus_err, exp_err);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [7:0] strb,
                          input logic [31:0] data, input logic [1:0] resp,
                          input int aww, input int ww, input int bw, input bit mess);
    int lat;
    logic [31:0] rd;
    start_txn();
    aw_cnt = aww; w_cnt = ww; b_cnt = bw; b_resp = resp;
    lsu_awaddr = addr; lsu_wstrb = strb; lsu_wdata = data;
    lsu_awvalid = 1; lsu_wvalid = 1;
    wait_pulse(1'b0, mess, lat, rd);
    if (ERR_EN && resp != 2'b00) exp_err = 1;
    chk("st_latency", lat, 3 + max2(aww, ww) + bw);
    chk("st_aw_count", aw_q.size(), 1);
    chk("st_w_count", w_q.size(), 1);
    if (aw_q.size() > 0) chk("st_aw_beat", aw_q[0], {exp_size(strb), addr});
    if (w_q.size() > 0)  chk("st_w_beat", w_q[0], exp_wbeat(addr, strb, data));
    chk("st_b_count", b_hs, 1);
    chk("st_no_ar", ar_q.size() + r_hs, 0);
    chk("bus_err", bus_err, exp_err);
  endtask

  function automatic logic [7:0] pick_strb();
    int k;
    k = $urandom_range(0, 4);
    case (k)
      0: return 8'h01;
      1: return 8'h03;
      2: return 8'h0f;
      3: return 8'h0f;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    bit seen;
    rst = 1; exp_err = 0;
    lsu_araddr = 0; lsu_arvalid = 0; lsu_rstrb = 0;
    lsu_awaddr = 0; lsu_awvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0;
    r_data = 0; r_resp = 0; b_resp = 0;
    repeat (3) @(negedge clk);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    chk("rst_pulses", {lsu_rvalid, lsu_wready, bus_err}, 3'b0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 0;

    // directed cases
    do_load(32'h8000_0004, 8'h0f, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0);
    do_store(32'h8000_0003, 8'h01, 32'h0000_00AB, 2'b00, 0, 0, 0, 0);
    do_store(32'h8000_0002, 8'h03, 32'h0000_1234, 2'b00, 3, 0, 0, 0);
    do_load(32'h1000_0001, 8'h01, 32'h1234_5678, 2'b00, 5, 0, 0, 0);
    do_load(32'h2000_0002, 8'h03, 32'hCAFE_F00D, 2'b00, 0, 0, 0, 1);
    do_store(32'h3000_0001, 8'h0f, 32'h1122_3344, 2'b00, 0, 2, 1, 0);

    // reset while waiting in RDATA
    start_txn();
    ar_cnt = 0; r_cnt = 50; lsu_araddr = 32'h4000_0000; lsu_rstrb = 8'h0f; lsu_arvalid = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rready) begin seen = 1; break; end
    end
    chk("reach_rdata", seen, 1'b1);
    rst = 1; exp_err = 0;
    #1;
    chk("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    drop_req();
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_pulse", {lsu_rvalid, lsu_wready}, 2'b00);
    end
    @(posedge clk); #1;
    rst = 0;
    do_load(32'h4000_0008, 8'h0f, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0);

    // error response on a word store, then a clean one (flag stays sticky)
    do_store(32'h5000_0000, 8'h0f, 32'hA5A5_5A5A, 2'b10, 0, 0, 0, 0);
    do_store(32'h5000_0004, 8'h0f, 32'h0101_0101, 2'b00, 0, 0, 0, 0);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      logic [1:0] resp;
      resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 1) == 1)
        do_load($urandom, pick_strb(), $urandom, resp,
                $urandom_range(0, 3), $urandom_range(0, 3),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 5) == 0));
      else
        do_store($urandom, pick_strb(), $urandom, resp,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
